alu_sched: RTL and testbench
============================

# alu_sched

Round-robin scheduler sharing one 12-bit arithmetic datapath (add/sub/mul/div/mod) between `N_REQ` requesters. It sits between the requesting engines and the combinational ALU. It arbitrates requests and latches the operands and opcode. It runs one operation at a time and returns a registered, tagged result through a valid/ready response port. Throughput is one operation per three cycles when there is no backpressure.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `ID_W`, default 2: requester tag width, equal to clog2(`N_REQ`).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request pending.
- `req_op`  in  4*N_REQ  opcode, slice i = [4i+3:4i].
- `req_a`  in  12*N_REQ  operand a, slice i.
- `req_b`  in  12*N_REQ  operand b, slice i.
- `req_ready`  out  N_REQ  one-hot accept; at most one bit high.
- `rsp_valid`  out  1  result available.
- `rsp_id`  out  ID_W  index of the requester that owns the result.
- `rsp_d`  out  32  result.
- `rsp_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in any state other than IDLE.
- `op_count`  out  16  number of completed responses; wraps at 0xFFFF->0.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - The grant goes to the first set `req_valid[i]` searching from `rr_ptr` upward, modulo `N_REQ`.
  - `req_ready[grant]` is high combinationally. There is no grant if no request is valid.
  - On handshake (valid & ready): latch op, a, b and the id; set `rr_ptr` = grant+1 mod `N_REQ`; go to EXEC.
- **EXEC**
  - Operands are zero-extended to 32 bits before the operation.
  - The ALU result is registered into `rsp_d`.
  - Go to RESP.
- **RESP**
  - `rsp_valid` is high.
  - On `rsp_ready`: increment `op_count` and go to IDLE.
  - `rsp_d` and `rsp_id` hold stable while `rsp_valid` is high and `rsp_ready` is low.
- **Opcodes** (result is 32 bits):
  - 0: a+b
  - 1: a−b, two's complement (so 3−5 = 0xFFFFFFFE)
  - 2: a*b
  - 3: a/b, unsigned
  - 4: a%b
  - 5..15: the opcode zero-extended.
- **Division by zero**
  - op 3 with b=0 gives 0xFFFFFFFF.
  - op 4 with b=0 gives a.
- **Request rules**
  - Requests are not accepted outside IDLE; `req_ready` is all-zero in that case.
  - A requester may drop `req_valid` without penalty.
  - Operand changes while `req_ready` is low are ignored.

## Timing
- Accept at cycle T. `rsp_valid` rises at T+2. The earliest next accept is at T+3, the cycle after the `rsp_ready` handshake.
- Reset values:
  - FSM = IDLE, `rr_ptr` = 0.
  - `req_ready` = 0 while `rst` is asserted.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_d` = 0.
  - `busy` = 0, `op_count` = 0.
- Reset asserted mid-operation drops the in-flight operation immediately and asynchronously. No response is produced and `op_count` does not increment.
- If every requester stays valid, each one is granted exactly once in any `N_REQ` consecutive grants. Worst-case wait is `N_REQ`−1 operations.
- `rsp_ready` high in EXEC has no effect. Only a handshake in RESP completes the operation.

## Structure
- **Shared package `alu_pkg`:**
  - opcode constants `OP_ADD`=0, `OP_SUB`=1, `OP_MUL`=2, `OP_DIV`=3, `OP_MOD`=4
  - FSM state enum {IDLE, EXEC, RESP}
  - operand width 12 and result width 32.
- **Sub-module `alu_core`:** the combinational datapath (op, a, b → d). It includes the divide-by-zero rules and is instantiated once.
- **Scheduler:** the arbiter, operand registers, FSM and counter live in `alu_sched` itself.

## Test plan
- **Single add:** requester 2 sends op=0, a=0xFFF, b=1, `rsp_ready` held high. Required: accept at T; at T+2 `rsp_valid`=1, `rsp_id`=2, `rsp_d`=0x1000; `op_count`=1.
- **Fairness:** all 4 requesters valid continuously with op=2, a=i+1, b=3. Required: grants in order 0,1,2,3,0; results 3,6,9,12,3; no requester granted twice in 4 grants.
- **Divide by zero and default opcode:**
  - op=3, a=7, b=0 gives 0xFFFFFFFF.
  - op=4, a=7, b=0 gives 7.
  - op=4, a=100, b=7 gives 2.
  - op=9 gives 0x00000009.
  - op=1, a=3, b=5 gives 0xFFFFFFFE.
- **Backpressure:** `rsp_ready` held low for 10 cycles. Required: `rsp_valid`, `rsp_id` and `rsp_d` stable throughout; `req_ready` all-zero even though `req_valid`=4'b1111; the next accept happens the cycle after the `rsp_ready` handshake.
- **Reset mid-op:** assert `rst` in EXEC. Required: `rsp_valid`=0, `busy`=0, `op_count` unchanged (0), and `rr_ptr` back to 0, so the first post-reset grant goes to requester 0 when all are valid.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcodes, FSM states
// and datapath widths.
package alu_pkg;

    localparam int OP_W   = 4;
    localparam int OPND_W = 12;
    localparam int RES_W  = 32;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV = 4'd3;
    localparam logic [OP_W-1:0] OP_MOD = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 12-bit ALU producing a 32-bit result; operands are
// zero-extended, and divide/modulo by zero return fixed values instead of X.
module alu_core
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [OPND_W-1:0] a_i,
    input  logic [OPND_W-1:0] b_i,
    output logic [RES_W-1:0]  d_o
);

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;

    assign a_ext = RES_W'(a_i);
    assign b_ext = RES_W'(b_i);

    always_comb begin
        d_o = RES_W'(op_i);
        case (op_i)
            OP_ADD:  d_o = a_ext + b_ext;
            OP_SUB:  d_o = a_ext - b_ext;
            OP_MUL:  d_o = a_ext * b_ext;
            OP_DIV:  d_o = (b_ext == '0) ? '1 : a_ext / b_ext;
            OP_MOD:  d_o = (b_ext == '0) ? a_ext : a_ext % b_ext;
            default: d_o = RES_W'(op_i);
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one alu_core between N_REQ requesters; one
// operation in flight, tagged registered result on a valid/ready port.
module alu_sched
    import alu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [OP_W*N_REQ-1:0]   req_op,
    input  logic [OPND_W*N_REQ-1:0] req_a,
    input  logic [OPND_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [RES_W-1:0]        rsp_d,
    input  logic                    rsp_ready,
    output logic                    busy,
    output logic [15:0]             op_count
);

    state_t            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_ptr_d;
    logic [ID_W-1:0]   id_q;
    logic [OP_W-1:0]   op_q;
    logic [OPND_W-1:0] a_q;
    logic [OPND_W-1:0] b_q;
    logic [RES_W-1:0]  rsp_d_q;
    logic              rsp_valid_q;
    logic              busy_q;
    logic [15:0]       op_count_q;

    logic              grant_valid;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W:0]     cand;
    logic [RES_W-1:0]  alu_d;

    logic [OP_W-1:0]   op_arr [N_REQ];
    logic [OPND_W-1:0] a_arr  [N_REQ];
    logic [OPND_W-1:0] b_arr  [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign op_arr[i] = req_op[OP_W*i +: OP_W];
        assign a_arr[i]  = req_a[OPND_W*i +: OPND_W];
        assign b_arr[i]  = req_b[OPND_W*i +: OPND_W];
    end

    // Scan from the far end back toward rr_ptr so the nearest valid requester
    // at or after the pointer is the last one written and wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (req_valid[cand[ID_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    assign rr_ptr_d  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    assign req_ready = (state_q == IDLE && grant_valid && !rst)
                       ? (N_REQ'(1) << grant_id) : '0;

    alu_core u_alu_core (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .d_o  (alu_d)
    );

    // NOTE: state registers use non-blocking assignments only, so every
    // branch sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_d_q     <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        op_q     <= op_arr[grant_id];
                        a_q      <= a_arr[grant_id];
                        b_q      <= b_arr[grant_id];
                        id_q     <= grant_id;
                        rr_ptr_q <= rr_ptr_d;
                        busy_q   <= 1'b1;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_d_q     <= alu_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        op_count_q  <= op_count_q + 16'd1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_d     = rsp_d_q;
    assign busy      = busy_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed scenarios plus randomized
// traffic compared against an arithmetic model of arbitration and results.
module tb_alu_sched;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [4*N-1:0]  req_op;
    logic [12*N-1:0] req_a;
    logic [12*N-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_d;
    logic            rsp_ready = 1'b0;
    logic            busy;
    logic [15:0]     op_count;

    logic [3:0]  t_op [N];
    logic [11:0] t_a  [N];
    logic [11:0] t_b  [N];

    int n_checks  = 0;
    int n_errors  = 0;
    int exp_ptr   = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        for (int i = 0; i < N; i++) begin
            req_op[4*i +: 4]  = t_op[i];
            req_a[12*i +: 12] = t_a[i];
            req_b[12*i +: 12] = t_b[i];
        end
    end

    alu_sched #(.N_REQ(N), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_d     (rsp_d),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .op_count  (op_count)
    );

    // Reference: result computed with plain integer arithmetic.
    function automatic logic [31:0] model_alu(input int op, input int a, input int b);
        longint r;
        case (op)
            0:       r = longint'(a) + longint'(b);
            1:       r = longint'(a) - longint'(b);
            2:       r = longint'(a) * longint'(b);
            3:       r = (b == 0) ? 64'hFFFF_FFFF : longint'(a / b);
            4:       r = (b == 0) ? longint'(a) : longint'(a % b);
            default: r = longint'(op);
        endcase
        return r[31:0];
    endfunction

    // Reference: nearest valid requester at or after the pointer, modulo N.
    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        exp_ptr   = 0;
        exp_count = 0;
    endtask

    // One full operation: wait for a grant, check EXEC, RESP and completion.
    // Entered and left at negedge+1 so a back-to-back accept is observed.
    task automatic serve(input int stall, output int gid, output logic [31:0] got_d,
                         output int waited);
        int             eg;
        logic [N-1:0]   exp_rdy;
        logic [31:0]    exp_d;
        logic [31:0]    hold_d;
        logic [IDW-1:0] hold_id;
        rsp_ready = (stall == 0);
        waited = 0;
        gid    = -1;
        got_d  = '0;
        #1;
        while (req_ready == '0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        eg = model_grant();
        n_checks++;
        if (req_ready == '0 || eg < 0) begin
            n_errors++;
            $display("FAIL grant_timeout: req_ready=%b req_valid=%b", req_ready, req_valid);
            return;
        end
        exp_rdy = N'(1) << eg;
        for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
        n_checks++;
        if (req_ready !== exp_rdy) begin
            n_errors++;
            $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
        end
        exp_d   = model_alu(int'(t_op[eg]), int'(t_a[eg]), int'(t_b[eg]));
        exp_ptr = (eg + 1) % N;

        @(negedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== '0) begin
            n_errors++;
            $display("FAIL exec_state: rsp_valid=%b busy=%b req_ready=%b expected 0 1 0000",
                     rsp_valid, busy, req_ready);
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== IDW'(eg) || rsp_d !== exp_d) begin
            n_errors++;
            $display("FAIL response: valid=%b id=%0d d=%h expected 1 %0d %h",
                     rsp_valid, rsp_id, rsp_d, eg, exp_d);
        end
        got_d   = rsp_d;
        hold_d  = rsp_d;
        hold_id = rsp_id;

        repeat (stall) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== hold_id || rsp_d !== hold_d ||
                req_ready !== '0) begin
                n_errors++;
                $display("FAIL hold: valid=%b id=%0d d=%h ready=%b expected 1 %0d %h 0000",
                         rsp_valid, rsp_id, rsp_d, req_ready, hold_id, hold_d);
            end
        end
        rsp_ready = 1'b1;

        @(negedge clk);
        #1;
        exp_count++;
        n_checks++;
        if (rsp_valid !== 1'b0 || op_count !== 16'(exp_count)) begin
            n_errors++;
            $display("FAIL complete: rsp_valid=%b op_count=%0d expected 0 %0d",
                     rsp_valid, op_count, exp_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        #1;
        n_checks++;
        if (req_ready !== '0) begin
            n_errors++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_d !== '0) begin
            n_errors++;
            $display("FAIL reset_rsp: valid=%b id=%0d d=%h expected 0 0 0", rsp_valid, rsp_id, rsp_d);
        end
        n_checks++;
        if (busy !== 1'b0 || op_count !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_status: busy=%b op_count=%0d expected 0 0", busy, op_count);
        end
        do_reset();
    endtask

    task automatic test_single_add();
        int gid, waited;
        logic [31:0] d;
        do_reset();
        t_op[2] = 4'd0;
        t_a[2]  = 12'hFFF;
        t_b[2]  = 12'h001;
        req_valid = 4'b0100;
        serve(0, gid, d, waited);
        req_valid = '0;
        n_checks++;
        if (gid != 2 || d !== 32'h0000_1000 || waited != 0 || op_count !== 16'd1) begin
            n_errors++;
            $display("FAIL single_add: id=%0d d=%h wait=%0d count=%0d expected 2 00001000 0 1",
                     gid, d, waited, op_count);
        end
    endtask

    task automatic test_fairness();
        int gid, waited;
        logic [31:0] d;
        logic [N-1:0] seen;
        do_reset();
        for (int i = 0; i < N; i++) begin
            t_op[i] = 4'd2;
            t_a[i]  = 12'(i + 1);
            t_b[i]  = 12'd3;
        end
        req_valid = '1;
        seen = '0;
        for (int k = 0; k < 5; k++) begin
            serve(0, gid, d, waited);
            n_checks++;
            if (gid != k % N || d !== 32'(3 * (k % N + 1)) || waited != 0) begin
                n_errors++;
                $display("FAIL fairness_%0d: id=%0d d=%0d wait=%0d expected %0d %0d 0",
                         k, gid, d, waited, k % N, 3 * (k % N + 1));
            end
            if (k < N && gid >= 0) seen[gid] = 1'b1;
        end
        req_valid = '0;
        n_checks++;
        if (seen !== '1) begin
            n_errors++;
            $display("FAIL fairness_window: granted set %b expected 1111", seen);
        end
    endtask

    task automatic test_opcodes();
        int gid, waited;
        logic [31:0] d;
        logic [3:0]  ops  [5] = '{4'd3, 4'd4, 4'd4, 4'd9, 4'd1};
        logic [11:0] as   [5] = '{12'd7, 12'd7, 12'd100, 12'd55, 12'd3};
        logic [11:0] bs   [5] = '{12'd0, 12'd0, 12'd7, 12'd66, 12'd5};
        logic [31:0] want [5] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd9, 32'hFFFF_FFFE};
        do_reset();
        req_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            t_op[1] = ops[k];
            t_a[1]  = as[k];
            t_b[1]  = bs[k];
            serve(0, gid, d, waited);
            n_checks++;
            if (d !== want[k]) begin
                n_errors++;
                $display("FAIL opcode_%0d: got %h expected %h", k, d, want[k]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int gid, waited;
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < N; i++) begin
            t_op[i] = 4'd0;
            t_a[i]  = 12'(100 * i);
            t_b[i]  = 12'd5;
        end
        req_valid = '1;
        serve(10, gid, d, waited);
        serve(0, gid, d, waited);
        n_checks++;
        if (waited != 0 || gid != 1) begin
            n_errors++;
            $display("FAIL backpressure_next: id=%0d wait=%0d expected 1 0", gid, waited);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_op();
        int gid, waited;
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < N; i++) begin
            t_op[i] = 4'd2;
            t_a[i]  = 12'(i + 10);
            t_b[i]  = 12'd2;
        end
        req_valid = '1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_errors++;
            $display("FAIL midop_first: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0 || req_ready !== '0) begin
            n_errors++;
            $display("FAIL midop_reset: valid=%b busy=%b count=%0d ready=%b expected 0 0 0 0000",
                     rsp_valid, busy, op_count, req_ready);
        end
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        exp_ptr   = 0;
        exp_count = 0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midop_regrant: ready=%b valid=%b expected 0001 0", req_ready, rsp_valid);
        end
        serve(0, gid, d, waited);
        req_valid = '0;
    endtask

    task automatic test_random();
        int gid, waited;
        logic [31:0] d;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                t_op[i] = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 4))
                                                       : 4'($urandom_range(0, 15));
                t_a[i]  = 12'($urandom_range(0, 4095));
                t_b[i]  = ($urandom_range(0, 4) == 0) ? 12'd0 : 12'($urandom_range(0, 4095));
            end
            req_valid = N'($urandom_range(1, 15));
            serve($urandom_range(0, 3), gid, d, waited);
            n_checks++;
            if (waited != 0) begin
                n_errors++;
                $display("FAIL random_latency_%0d: waited %0d cycles expected 0", n, waited);
            end
        end
        req_valid = '0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            t_op[i] = '0;
            t_a[i]  = '0;
            t_b[i]  = '0;
        end
        test_reset();
        test_single_add();
        test_fairness();
        test_opcodes();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
